simple_rx_fifo: RTL
===================

Name: simple_rx_fifo

Overview:
Receive-side counterpart to the AXI4-Lite transmit FIFO peripheral. It accepts 32-bit words on an AXI4-Stream slave port and buffers them in an internal FIFO. The processor drains the FIFO and reads status through a 4-register AXI4-Lite slave. An interrupt line signals when the fill level reaches a programmable threshold.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI-Lite data width; fixed at 32.
C_S_AXI_ADDR_WIDTH, 4, AXI-Lite address width; 4 registers at a word stride.
FIFO_DEPTH, 16, FIFO entries; power of 2, range 4..256.
CNT_W, $clog2(FIFO_DEPTH)+1, width of the fill count.

Ports:
ACLK  in  1  single clock for all logic
ARESET  in  1  asynchronous, active-high reset
s_axis_tdata  in  32  stream data
s_axis_tvalid  in  1  stream valid
s_axis_tready  out  1  stream ready
s_axis_tlast  in  1  end-of-packet marker
s_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address
s_axi_awvalid / s_axi_awready  in/out  1  write address handshake
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte strobes
s_axi_wvalid / s_axi_wready  in/out  1  write data handshake
s_axi_bresp  out  2  write response; always 2'b00
s_axi_bvalid / s_axi_bready  out/in  1  write response handshake
s_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address
s_axi_arvalid / s_axi_arready  in/out  1  read address handshake
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  read response; always 2'b00
s_axi_rvalid / s_axi_rready  out/in  1  read data handshake
irq  out  1  level interrupt, registered

Behaviour:
- Reset (async assert, release on ACLK): FIFO empty, count=0, THRESH=0, underflow=0. All ready and valid outputs, irq, and rdata are 0.
- Stream side:
  - s_axis_tready = !full, registered from next-state count.
  - Push on tvalid&&tready.
- Register map:
  - 0x0 DATA (RO): a read pops the head word.
  - 0x4 STATUS (RO): [CNT_W-1:0]=count, [16]=empty, [17]=full, [18]=underflow sticky, [19]=head tlast (optional feature, else 0).
  - 0x8 CONTROL (WO, reads 0): bit0=flush, self-clearing; bit1=clear underflow.
  - 0xC THRESH (RW): [7:0], honours wstrb[0].
- Write channel:
  - awready and wready pulse high together for one cycle when awvalid&&wvalid&&!bvalid.
  - Register update occurs on that cycle.
  - bvalid rises the next cycle and holds until bready.
  - Writes to RO or unmapped addresses are ignored and still return OKAY.
- Read channel:
  - arready pulses for one cycle when arvalid&&!rvalid; the address is latched.
  - rvalid rises the next cycle with rdata and holds stable until rready.
  - Only one read is outstanding at a time.
  - The DATA pop is committed on the arready cycle.
  - A DATA read while empty returns 0, sets underflow sticky, and does not move the pointers.
  - Unmapped reads return 0.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Push to a FIFO holding 1 entry with a simultaneous pop: legal; the new word becomes head.
- Flush:
  - Pointers and count go to 0 on the write-handshake cycle.
  - A push on the same cycle is discarded; tready is 0 for that cycle.
  - A pending pop on the same cycle is discarded; flush wins.
- Pointers wrap modulo FIFO_DEPTH; full when count==FIFO_DEPTH.
- irq register = (THRESH!=0) && (count>=THRESH), one cycle after the count changes.
- Reset mid-transaction: all channels abort, outstanding B/R responses are dropped, and contents are lost.

Optional Feature:
Macro RX_FIFO_TLAST_TRACK_EN.
- Defined: FIFO width becomes 33, storing tlast with each word. STATUS[19] shows the head entry's tlast (0 when empty). A packet-count register at 0x8-read returns the number of buffered tlast words, and irq also asserts when that count is nonzero.
- Undefined: tlast is ignored, STATUS[19]=0, 0x8 reads 0.

Test Plan:
- Reset, then read STATUS -> 0x00010000 (empty); s_axis_tready=1; irq=0.
- Stream 0x0101FFFF, 0xabcd0001, 0xdead0011, 0xbeef0011, then four DATA reads -> words returned in order; final STATUS=0x00010000; every bresp/rresp=0.
- Push 16 words with DEPTH=16 -> tready=0 and STATUS=0x00020010. One DATA read with tvalid held -> count stays 16; next word accepted on the cycle after the pop.
- Write THRESH=4, push 3 words -> irq=0; push a 4th -> irq=1 one cycle later. Pop 1 -> irq=0.
- DATA read while empty -> rdata=0 and STATUS[18]=1. Write CONTROL=0x2 -> STATUS[18]=0.
- With 5 words buffered, write CONTROL=0x1 during tvalid -> that word is dropped and STATUS=0x00010000. Assert ARESET mid-read -> rvalid=0 immediately.

Source files
------------

// File: rtl/simple_rx_fifo.sv
// simple_rx_fifo: AXI4-Stream slave feeding a word FIFO, drained and
// controlled through a 4-register AXI4-Lite slave, with a threshold irq.
// Optional feature macro: RX_FIFO_TLAST_TRACK_EN (stores tlast per entry,
// exposes head tlast in STATUS[19] and a packet count at 0x8).
module simple_rx_fifo #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH         = 16,
  parameter int CNT_W              = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [31:0]                   s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [3:0]                    s_axi_wstrb,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  output logic                          irq
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
`ifdef RX_FIFO_TLAST_TRACK_EN
  localparam int MEM_W = 33;
`else
  localparam int MEM_W = 32;
`endif

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_THRESH = 2'd3
  } reg_sel_e;

  logic [MEM_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_tready;
  logic             r_uf;
  logic [7:0]       r_thresh;
  logic             r_irq;
  logic             r_awready, r_bvalid;
  logic             r_arready, r_rvalid;
  logic [31:0]      r_rdata;

  reg_sel_e         w_wsel, w_rsel;
  logic             w_aw_start, w_wr_hs, w_rd_hs;
  logic             w_flush, w_flush_nxt, w_clr_uf;
  logic             w_empty, w_full;
  logic             w_data_rd, w_pop, w_push, w_underflow;
  logic [CNT_W-1:0] w_count_nxt;
  logic [MEM_W-1:0] w_head;
  logic             w_head_last;
  logic             w_pkt_nz;
  logic [31:0]      w_status, w_rdata, w_ctrl_rd;
  logic             w_unused;

  assign w_wsel      = reg_sel_e'(s_axi_awaddr[3:2]);
  assign w_rsel      = reg_sel_e'(s_axi_araddr[3:2]);
  assign w_aw_start  = s_axi_awvalid && s_axi_wvalid && !r_bvalid && !r_awready;
  assign w_wr_hs     = r_awready && s_axi_awvalid && s_axi_wvalid;
  assign w_flush     = w_wr_hs && (w_wsel == REG_CTRL) && s_axi_wdata[0];
  assign w_clr_uf    = w_wr_hs && (w_wsel == REG_CTRL) && s_axi_wdata[1];
  // tready is registered, so a flush is predicted one cycle ahead from the
  // write that is about to be accepted; this keeps tready low on the flush cycle.
  assign w_flush_nxt = w_aw_start && (w_wsel == REG_CTRL) && s_axi_wdata[0];
  assign w_rd_hs     = r_arready && s_axi_arvalid;
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_data_rd   = w_rd_hs && (w_rsel == REG_DATA);
  assign w_pop       = w_data_rd && !w_empty && !w_flush;
  assign w_underflow = w_data_rd && w_empty;
  assign w_push      = s_axis_tvalid && r_tready && !w_flush;
  assign w_head      = r_mem[r_rptr];

`ifdef RX_FIFO_TLAST_TRACK_EN
  logic [CNT_W-1:0] r_pkt;
  assign w_head_last = !w_empty && w_head[32];
  assign w_pkt_nz    = (r_pkt != '0);
  assign w_ctrl_rd   = 32'(r_pkt);
  assign w_unused    = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_wstrb[3:1],
                         s_axi_wdata[31:8]};

  // Count of buffered words that carry tlast
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_pkt <= '0;
    end else if (w_flush) begin
      r_pkt <= '0;
    end else begin
      r_pkt <= r_pkt + CNT_W'(w_push && s_axis_tlast) - CNT_W'(w_pop && w_head_last);
    end
  end
`else
  assign w_head_last = 1'b0;
  assign w_pkt_nz    = 1'b0;
  assign w_ctrl_rd   = '0;
  assign w_unused    = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_wstrb[3:1],
                         s_axi_wdata[31:8], s_axis_tlast};
`endif

  // Next fill level: flush overrides any push/pop in the same cycle
  always_comb begin
    w_count_nxt = r_count;
    if (w_flush) begin
      w_count_nxt = '0;
    end else if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  // STATUS word and read-data mux
  always_comb begin
    w_status              = '0;
    w_status[CNT_W-1:0]   = r_count;
    w_status[16]          = w_empty;
    w_status[17]          = w_full;
    w_status[18]          = r_uf;
    w_status[19]          = w_head_last;
    w_rdata               = '0;
    case (w_rsel)
      REG_DATA:   w_rdata = w_empty ? '0 : w_head[31:0];
      REG_STATUS: w_rdata = w_status;
      REG_CTRL:   w_rdata = w_ctrl_rd;
      REG_THRESH: w_rdata = {24'd0, r_thresh};
      default:    w_rdata = '0;
    endcase
  end

  // FIFO storage; contents are not reset
  always_ff @(posedge ACLK) begin
    if (w_push) begin
      r_mem[r_wptr] <= MEM_W'({s_axis_tlast, s_axis_tdata});
    end
  end

  // Pointers, count and stream-side ready
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_tready <= 1'b0;
    end else begin
      r_count  <= w_count_nxt;
      r_tready <= (w_count_nxt != CNT_W'(FIFO_DEPTH)) && !w_flush_nxt;
      if (w_flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + PTR_W'(1);
        if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      end
    end
  end

  // Software-visible registers: threshold and sticky underflow
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_thresh <= '0;
      r_uf     <= 1'b0;
    end else begin
      if (w_wr_hs && (w_wsel == REG_THRESH) && s_axi_wstrb[0]) begin
        r_thresh <= s_axi_wdata[7:0];
      end
      if (w_underflow) begin
        r_uf <= 1'b1;
      end else if (w_clr_uf) begin
        r_uf <= 1'b0;
      end
    end
  end

  // Interrupt follows the registered count by one cycle
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= ((r_thresh != '0) && (32'(r_count) >= 32'(r_thresh))) || w_pkt_nz;
    end
  end

  // AXI-Lite write channel: one-cycle aw/w ready pulse, then B response
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
    end else begin
      r_awready <= w_aw_start;
      if (w_wr_hs) begin
        r_bvalid <= 1'b1;
      end else if (r_bvalid && s_axi_bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // AXI-Lite read channel: one read outstanding, data captured at arready
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_arready <= s_axi_arvalid && !r_rvalid && !r_arready;
      if (w_rd_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rdata;
      end else if (r_rvalid && s_axi_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign s_axis_tready = r_tready;
  assign s_axi_awready = r_awready;
  assign s_axi_wready  = r_awready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = C_S_AXI_DATA_WIDTH'(r_rdata);
  assign s_axi_rresp   = 2'b00;
  assign irq           = r_irq;

endmodule
